// File: rtl/dds_ui_pkg.sv
// Shared definitions for the DDS generator user-interface blocks:
// hex glyph table, blank pattern and the default output polarity.
package dds_ui_pkg;

    // Display outputs default to active-low (common-anode style drivers).
    localparam bit ACT_LOW_DEF = 1'b1;

    // Active-high blank pattern, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high hex glyphs 0..F, element 0 first.
    localparam logic [0:15][6:0] SEG_LUT = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Converts an active-high segment pattern to the pin polarity.
    function automatic logic [6:0] seg_pol(input logic [6:0] seg, input bit act_low);
        return act_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg7_scan_if_if.sv
// Control-logic <-> display-scanner signal bundle.
// master: control logic side, slave: display scanner side.
interface seg7_scan_if_if #(
    parameter int NUM_DIG = 4
);
    logic                   iLoad;
    logic [4*NUM_DIG-1:0]   iDigits;
    logic [NUM_DIG-1:0]     iDpMask;
    logic                   iLzbEn;
    logic                   iBlinkEn;
    logic [2:0]             iBlinkSel;
    logic [6:0]             oSeg;
    logic                   oDp;
    logic [NUM_DIG-1:0]     oAn;
    logic                   oUpd;

    modport master (
        output iLoad, iDigits, iDpMask, iLzbEn, iBlinkEn, iBlinkSel,
        input  oSeg, oDp, oAn, oUpd
    );

    modport slave (
        input  iLoad, iDigits, iDpMask, iLzbEn, iBlinkEn, iBlinkSel,
        output oSeg, oDp, oAn, oUpd
    );
endinterface

// File: rtl/seg7_decode.sv
// 4-bit hex code to active-high 7-segment pattern, purely combinational.
module seg7_decode
    import dds_ui_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_LUT[i_code];

endmodule

// File: rtl/seg7_scan_if.sv
// Multiplexed 7-segment display scanner with tear-free word updates,
// leading-zero blanking and single-digit blinking.
module seg7_scan_if
    import dds_ui_pkg::*;
#(
    parameter int NUM_DIG   = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64,
    parameter bit ACT_LOW   = ACT_LOW_DEF
) (
    input  logic            Fg_CLK,
    input  logic            RESETn,
    seg7_scan_if_if.slave   bus
);

    localparam int W_SCAN = $clog2(SCAN_DIV);
    localparam int W_IDX  = $clog2(NUM_DIG);
    // BLINK_DIV=1 still needs a 1-bit counter that wraps every frame.
    localparam int W_FRM  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [W_SCAN-1:0] SCAN_LAST = W_SCAN'(SCAN_DIV - 1);
    localparam logic [W_IDX-1:0]  IDX_LAST  = W_IDX'(NUM_DIG - 1);
    localparam logic [W_FRM-1:0]  FRM_LAST  = W_FRM'(BLINK_DIV - 1);
    localparam logic [NUM_DIG-1:0] AN_POL   = {NUM_DIG{ACT_LOW}};

    logic [W_SCAN-1:0]      r_scan;
    logic [W_IDX-1:0]       r_idx;
    logic [W_FRM-1:0]       r_frm;
    logic                   r_blink_on;
    logic                   r_pend;
    logic [4*NUM_DIG-1:0]   r_pend_dig;
    logic [NUM_DIG-1:0]     r_pend_dp;
    logic [4*NUM_DIG-1:0]   r_disp_dig;
    logic [NUM_DIG-1:0]     r_disp_dp;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic [NUM_DIG-1:0]     r_an;

    logic                   w_slot_end;
    logic                   w_fb;
    logic                   w_upd;
    logic                   w_zero_run;
    logic [NUM_DIG-1:0]     w_lzb_vec;
    logic [3:0]             w_code;
    logic                   w_dp_bit;
    logic                   w_lzb_hit;
    logic [NUM_DIG-1:0]     w_an_hot;
    logic                   w_blink_hit;
    logic                   w_blank;
    logic [6:0]             w_seg_dec;

    assign w_slot_end = (r_scan == SCAN_LAST);
    assign w_fb       = w_slot_end && (r_idx == IDX_LAST);
    assign w_upd      = w_fb && (r_pend || bus.iLoad);

    // Slot timer and digit index; index wrap to 0 marks the frame boundary.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (w_slot_end) begin
            r_scan <= '0;
            r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + W_IDX'(1);
        end else begin
            r_scan <= r_scan + W_SCAN'(1);
        end
    end

    // Frame counter toggles the blink phase every BLINK_DIV frames.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_frm      <= '0;
            r_blink_on <= 1'b1;
        end else if (w_fb) begin
            if (r_frm == FRM_LAST) begin
                r_frm      <= '0;
                r_blink_on <= ~r_blink_on;
            end else begin
                r_frm <= r_frm + W_FRM'(1);
            end
        end
    end

    // Loads land in the pending word; display only changes at a frame boundary,
    // and a load coinciding with the boundary bypasses straight to the display.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_pend     <= 1'b0;
            r_pend_dig <= '0;
            r_pend_dp  <= '0;
            r_disp_dig <= '0;
            r_disp_dp  <= '0;
        end else if (w_fb) begin
            r_pend <= 1'b0;
            if (bus.iLoad) begin
                r_disp_dig <= bus.iDigits;
                r_disp_dp  <= bus.iDpMask;
            end else if (r_pend) begin
                r_disp_dig <= r_pend_dig;
                r_disp_dp  <= r_pend_dp;
            end
        end else if (bus.iLoad) begin
            r_pend     <= 1'b1;
            r_pend_dig <= bus.iDigits;
            r_pend_dp  <= bus.iDpMask;
        end
    end

    // Digit k is blankable when it and every digit above it are zero with no dp.
    always_comb begin
        w_zero_run = 1'b1;
        w_lzb_vec  = '0;
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            w_zero_run   = w_zero_run && (r_disp_dig[4*k +: 4] == 4'h0) && !r_disp_dp[k];
            w_lzb_vec[k] = w_zero_run && (k != 0);
        end
    end

    // Select the current digit's code, dp and blanking flag; build the one-hot enable.
    always_comb begin
        w_code    = 4'h0;
        w_dp_bit  = 1'b0;
        w_lzb_hit = 1'b0;
        w_an_hot  = '0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (r_idx == W_IDX'(k)) begin
                w_code      = r_disp_dig[4*k +: 4];
                w_dp_bit    = r_disp_dp[k];
                w_lzb_hit   = w_lzb_vec[k];
                w_an_hot[k] = 1'b1;
            end
        end
    end

    assign w_blink_hit = bus.iBlinkEn && !r_blink_on && (3'(r_idx) == bus.iBlinkSel);
    assign w_blank     = (bus.iLzbEn && w_lzb_hit) || w_blink_hit;

    seg7_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_seg_dec)
    );

    // Output stage: masked glyph, dp and anode enables (dark in slot's first cycle).
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_seg <= seg_pol(SEG_OFF, ACT_LOW);
            r_dp  <= ACT_LOW;
            r_an  <= AN_POL;
        end else begin
            r_seg <= seg_pol(w_blank ? SEG_OFF : w_seg_dec, ACT_LOW);
            r_dp  <= (w_dp_bit && !w_blank) ^ ACT_LOW;
            r_an  <= ((r_scan == '0) ? '0 : w_an_hot) ^ AN_POL;
        end
    end

    assign bus.oSeg = r_seg;
    assign bus.oDp  = r_dp;
    assign bus.oAn  = r_an;
    assign bus.oUpd = w_upd;

endmodule
